deduplicate_fifo: RTL and testbench

DEDUPLICATE_FIFO -- requirements
Module: deduplicate_fifo

---
 rtl/deduplicate_fifo.sv | 116 +++++++++++
 tb/tb_deduplicate_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/deduplicate_fifo.sv
// deduplicate_fifo: FIFO for a stream that carries every word twice.
// The write side accepts each pair, keeps one copy and flags pairs whose two
// halves disagree. The read side is a first-word-fall-through FIFO.
module deduplicate_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] write_data,
  output logic          full,
  input  logic          pop,
  output logic [DW-1:0] read_data,
  output logic          empty,
  output logic          pending,
  output logic          mismatch
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } wr_state_t;

  wr_state_t     state, state_next;
  logic [DW-1:0] hold;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic push_ok, pop_ok;
  logic hold_load, store_wr, mismatch_next;

  // Acceptance is decided from the occupancy before the edge, so a pop while
  // full never frees room for a push in the same cycle.
  assign full    = (count == AW'(0) + (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pending = (state == SECOND);

  // Write-side FSM: state register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) state <= FIRST;
    else      state <= state_next;
  end

  // Write-side FSM: next state and pair decision.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves a value unassigned, which would infer a latch.
    state_next    = state;
    hold_load     = 1'b0;
    store_wr      = 1'b0;
    mismatch_next = 1'b0;
    unique case (state)
      FIRST: begin
        if (push_ok) begin
          hold_load  = 1'b1;
          state_next = SECOND;
        end
      end
      SECOND: begin
        if (push_ok) begin
          state_next = FIRST;
          if (write_data == hold) store_wr      = 1'b1;
          else                    mismatch_next = 1'b1;
        end
      end
      default: state_next = FIRST;
    endcase
  end

  // Hold register for the first word of a pair, and the registered mismatch pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold     <= '0;
      mismatch <= 1'b0;
    end else begin
      if (hold_load) hold <= write_data;
      mismatch <= mismatch_next;
    end
  end

  // Storage array: written with the held word when a pair completes.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; empty gates every read, so
    // stale contents are never observed and the memory can map to plain RAM.
    if (store_wr) mem[wr_ptr] <= hold;
  end

  // Pointers and occupancy count; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({store_wr, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // First-word-fall-through head of the store.
  assign read_data = mem[rd_ptr];

endmodule

// File: tb/tb_deduplicate_fifo.sv
// tb_deduplicate_fifo: scoreboard bench for deduplicate_fifo.
// The driver keeps a queue-based reference model of the pair rules; accepted
// pops enqueue the expected word, and an independent monitor checks every
// popped word plus the status flags each cycle.
module tb_deduplicate_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic [DW-1:0] write_data;
  logic          full;
  logic          pop;
  logic [DW-1:0] read_data;
  logic          empty;
  logic          pending;
  logic          mismatch;

  deduplicate_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .write_data (write_data),
    .full       (full),
    .pop        (pop),
    .read_data  (read_data),
    .empty      (empty),
    .pending    (pending),
    .mismatch   (mismatch)
  );

  always #5 clk = ~clk;

  // Reference model state (value after the most recent edge).
  logic [DW-1:0] m_store [$];
  logic          m_pend;
  logic [DW-1:0] m_hold;
  logic          m_mm;

  // Expected words for accepted pops.
  logic [DW-1:0] exp_q [$];

  int n_cmp  = 0;
  int n_fail = 0;
  int n_pops = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic model_clear();
    m_store.delete();
    m_pend = 1'b0;
    m_hold = '0;
    m_mm   = 1'b0;
  endtask

  // One clock of stimulus; the model is advanced after the edge.
  task automatic step(input logic p, input logic [DW-1:0] d, input logic q);
    logic push_acc, pop_acc, wr, mmn, pend_n;
    logic [DW-1:0] hold_n;
    push       = p;
    write_data = d;
    pop        = q;
    pop_acc  = q && (m_store.size() != 0);
    push_acc = p && (m_store.size() != DEPTH);
    if (pop_acc) exp_q.push_back(m_store[0]);
    wr = 1'b0; mmn = 1'b0; pend_n = m_pend; hold_n = m_hold;
    if (push_acc) begin
      if (!m_pend) begin
        hold_n = d;
        pend_n = 1'b1;
      end else begin
        pend_n = 1'b0;
        if (d == m_hold) wr = 1'b1;
        else             mmn = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (pop_acc) void'(m_store.pop_front());
    if (wr) m_store.push_back(m_hold);
    m_pend = pend_n;
    m_hold = hold_n;
    m_mm   = mmn;
  endtask

  task automatic do_reset();
    push = 1'b0;
    pop  = 1'b0;
    rst  = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: status flags every cycle, popped data against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_empty",    32'(empty),    32'd1);
      check("rst_full",     32'(full),     32'd0);
      check("rst_pending",  32'(pending),  32'd0);
      check("rst_mismatch", 32'(mismatch), 32'd0);
    end else begin
      check("full",     32'(full),     32'(m_store.size() == DEPTH));
      check("empty",    32'(empty),    32'(m_store.size() == 0));
      check("pending",  32'(pending),  32'(m_pend));
      check("mismatch", 32'(mismatch), 32'(m_mm));
      if (pop && !empty) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 32'd1, 32'd0);
        end else begin
          check("read_data", 32'(read_data), 32'(exp_q.pop_front()));
          n_pops++;
        end
      end
    end
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] dir_data [12];
    push = 1'b0; pop = 1'b0; write_data = '0; rst = 1'b0;
    model_clear();
    do_reset();

    // Fill with four clean pairs.
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, DW'(i), 1'b0);
      step(1'b1, DW'(i), 1'b0);
    end
    check("filled_full", 32'(full), 32'd1);

    // Pushes while full are ignored, then drain.
    step(1'b1, DW'(5), 1'b0);
    step(1'b1, DW'(5), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    check("drained_empty", 32'(empty), 32'd1);

    // Pop while empty is ignored.
    step(1'b0, '0, 1'b1);

    // Differing pair produces a single mismatch pulse.
    step(1'b1, DW'(7), 1'b0);
    check("pend_after_first", 32'(pending), 32'd1);
    step(1'b1, DW'(9), 1'b0);
    check("pulse_after_diff", 32'(mismatch), 32'd1);
    step(1'b0, '0, 1'b0);
    check("pulse_one_cycle", 32'(mismatch), 32'd0);

    // Continuous pushes with pops starting on the fifth push.
    dir_data = '{7, 7, 14, 14, 4, 4, 13, 13, 25, 25, 32, 32};
    for (int i = 0; i < 12; i++) step(1'b1, dir_data[i], i >= 4);
    while (!empty && m_store.size() != 0) step(1'b0, '0, 1'b1);

    // Reset in the middle of a pair discards the held word.
    step(1'b1, DW'(8), 1'b0);
    do_reset();
    step(1'b1, DW'(9), 1'b0);
    step(1'b1, DW'(9), 1'b0);
    check("after_rst_pending", 32'(pending), 32'd0);
    check("after_rst_head", 32'(read_data), 32'd9);
    step(1'b0, '0, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset();
      if (m_pend && ($urandom_range(0, 9) < 8)) v = m_hold;
      else                                     v = DW'($urandom_range(0, 255));
      step($urandom_range(0, 9) < 7, v, $urandom_range(0, 9) < 4);
    end
    while (m_store.size() != 0) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("pops_seen", 32'(n_pops > 20), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
